// File: rtl/memory_stage_pkg.sv
// Shared MEM-stage types: FSM state, default widths, and the control bundle carried EX->MEM->WB.
package memory_stage_pkg;

    localparam int MS_DATA_W = 16;
    localparam int MS_REG_AW = 3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/memory_stage_if.sv
// EX-result, data-memory and write-back signals of the MEM stage; master = surrounding pipeline, slave = memory_stage.
interface memory_stage_if
    import memory_stage_pkg::*;
#(
    parameter int DATA_W = MS_DATA_W,
    parameter int REG_AW = MS_REG_AW
);
    logic              ex_valid;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_branch_target;
    logic              ex_zero;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_AW-1:0] ex_write_reg;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;
    logic              ex_reg_write;
    logic              ex_mem_to_reg;

    logic              stall;
    logic              pc_src;
    logic [DATA_W-1:0] branch_target;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    logic              wb_valid;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_write_reg;
    logic [DATA_W-1:0] wb_data;

    logic              err;

    modport master (
        output ex_valid, ex_alu_result, ex_branch_target, ex_zero, ex_store_data,
               ex_write_reg, ex_mem_read, ex_mem_write, ex_branch, ex_reg_write,
               ex_mem_to_reg, dmem_rdata, dmem_ack,
        input  stall, pc_src, branch_target, dmem_req, dmem_we, dmem_addr,
               dmem_wdata, wb_valid, wb_reg_write, wb_write_reg, wb_data, err
    );

    modport slave (
        input  ex_valid, ex_alu_result, ex_branch_target, ex_zero, ex_store_data,
               ex_write_reg, ex_mem_read, ex_mem_write, ex_branch, ex_reg_write,
               ex_mem_to_reg, dmem_rdata, dmem_ack,
        output stall, pc_src, branch_target, dmem_req, dmem_we, dmem_addr,
               dmem_wdata, wb_valid, wb_reg_write, wb_write_reg, wb_data, err
    );

endinterface

// File: rtl/memory_stage_mem_wait_timer.sv
// Counts cycles spent waiting for a data-memory ack; o_expire flags the last permitted WAIT cycle.
// Latency: expire is combinational from the count; no backpressure of its own.
module mem_wait_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    // The FSM leaves WAIT on expire, so the count never passes TIMEOUT_CYC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = (r_cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/memory_stage.sv
// MEM stage: EX/MEM register, branch resolve, req/ack data-memory access with timeout, MEM/WB register.
// Latency: 2 cycles EX->WB; an unacked memory request stalls upstream and bubbles WB until ack.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DATA_W      = MS_DATA_W,
    parameter int REG_AW      = MS_REG_AW,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    memory_stage_if.slave bus
);
    mem_state_t        r_state;
    mem_state_t        w_next_state;

    logic              r_exm_valid;
    logic [DATA_W-1:0] r_exm_alu_result;
    logic [DATA_W-1:0] r_exm_branch_target;
    logic              r_exm_zero;
    logic [DATA_W-1:0] r_exm_store_data;
    logic [REG_AW-1:0] r_exm_write_reg;
    ctrl_t             r_exm_ctrl;

    logic              r_wb_valid;
    logic              r_wb_reg_write;
    logic [REG_AW-1:0] r_wb_write_reg;
    logic [DATA_W-1:0] r_wb_data;

    ctrl_t             w_ex_ctrl;
    logic              w_mem_op;
    logic              w_req;
    logic              w_stall;
    logic              w_pc_src;
    logic              w_timer_clear;
    logic              w_timer_inc;
    logic              w_expire;
    logic [DATA_W-1:0] w_wb_data;

    assign w_ex_ctrl = '{
        mem_read:   bus.ex_mem_read,
        mem_write:  bus.ex_mem_write,
        branch:     bus.ex_branch,
        reg_write:  bus.ex_reg_write,
        mem_to_reg: bus.ex_mem_to_reg
    };

    assign w_mem_op  = r_exm_valid & (r_exm_ctrl.mem_read | r_exm_ctrl.mem_write);
    assign w_req     = w_mem_op & (r_state != ST_ERR);
    assign w_stall   = (w_req & ~bus.dmem_ack) | (r_state == ST_ERR);
    assign w_pc_src  = r_exm_valid & r_exm_ctrl.branch & r_exm_zero;
    assign w_wb_data = r_exm_ctrl.mem_to_reg ? bus.dmem_rdata : r_exm_alu_result;

    // A taken branch squashes the instruction EX fetched down the wrong path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exm_valid         <= 1'b0;
            r_exm_alu_result    <= '0;
            r_exm_branch_target <= '0;
            r_exm_zero          <= 1'b0;
            r_exm_store_data    <= '0;
            r_exm_write_reg     <= '0;
            r_exm_ctrl          <= '0;
        end else if (!w_stall) begin
            r_exm_valid         <= bus.ex_valid & ~w_pc_src;
            r_exm_alu_result    <= bus.ex_alu_result;
            r_exm_branch_target <= bus.ex_branch_target;
            r_exm_zero          <= bus.ex_zero;
            r_exm_store_data    <= bus.ex_store_data;
            r_exm_write_reg     <= bus.ex_write_reg;
            r_exm_ctrl          <= w_ex_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_write_reg <= '0;
            r_wb_data      <= '0;
        end else if (w_stall) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
        end else begin
            r_wb_valid     <= r_exm_valid;
            r_wb_reg_write <= r_exm_valid & r_exm_ctrl.reg_write;
            r_wb_write_reg <= r_exm_write_reg;
            r_wb_data      <= w_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ack is tested before expire so a response on the last allowed cycle still completes.
    always_comb begin
        w_next_state  = r_state;
        w_timer_clear = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_req && !bus.dmem_ack) begin
                    w_next_state  = ST_WAIT;
                    w_timer_clear = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.dmem_ack) begin
                    w_next_state = ST_RUN;
                end else if (w_expire) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_ERR: begin
                w_next_state = ST_ERR;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    assign w_timer_inc = (r_state == ST_WAIT);

    mem_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_timer_clear),
        .i_inc    (w_timer_inc),
        .o_expire (w_expire)
    );

    assign bus.stall         = w_stall;
    assign bus.pc_src        = w_pc_src;
    assign bus.branch_target = r_exm_branch_target;
    assign bus.dmem_req      = w_req;
    assign bus.dmem_we       = r_exm_ctrl.mem_write;
    assign bus.dmem_addr     = {r_exm_alu_result[DATA_W-1:1], 1'b0};
    assign bus.dmem_wdata    = r_exm_store_data;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_reg_write  = r_wb_reg_write;
    assign bus.wb_write_reg  = r_wb_write_reg;
    assign bus.wb_data       = r_wb_data;
    assign bus.err           = (r_state == ST_ERR);

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with an instruction-level reference model checked every cycle.
module tb_memory_stage;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    memory_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus();

    memory_stage #(
        .DATA_W      (DW),
        .REG_AW      (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The instruction sitting in MEM, how many cycles it has been stalled, and the last retired result.
    typedef struct packed {
        logic          valid;
        logic [DW-1:0] alu;
        logic [DW-1:0] tgt;
        logic          zero;
        logic [DW-1:0] sdata;
        logic [AW-1:0] wreg;
        logic          rd;
        logic          wr;
        logic          br;
        logic          rw;
        logic          m2r;
    } instr_t;

    instr_t        m_slot = '0;
    int            m_stalled = 0;
    logic          m_err = 1'b0;
    logic          m_wb_valid = 1'b0;
    logic          m_wb_rw = 1'b0;
    logic [AW-1:0] m_wb_reg = '0;
    logic [DW-1:0] m_wb_data = '0;
    logic          m_req, m_taken;

    function automatic instr_t ex_now();
        instr_t t;
        t.valid = bus.ex_valid;
        t.alu   = bus.ex_alu_result;
        t.tgt   = bus.ex_branch_target;
        t.zero  = bus.ex_zero;
        t.sdata = bus.ex_store_data;
        t.wreg  = bus.ex_write_reg;
        t.rd    = bus.ex_mem_read;
        t.wr    = bus.ex_mem_write;
        t.br    = bus.ex_branch;
        t.rw    = bus.ex_reg_write;
        t.m2r   = bus.ex_mem_to_reg;
        return t;
    endfunction

    // A memory op may stay unacknowledged for one issue cycle plus TO wait cycles; one more is an error.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_slot = '0; m_stalled = 0; m_err = 1'b0;
            m_wb_valid = 1'b0; m_wb_rw = 1'b0; m_wb_reg = '0; m_wb_data = '0;
        end else begin
            m_req   = m_slot.valid && (m_slot.rd || m_slot.wr) && !m_err;
            m_taken = m_slot.valid && m_slot.br && m_slot.zero;
            if (m_err || (m_req && !bus.dmem_ack)) begin
                if (!m_err) begin
                    if (m_stalled == TO) m_err = 1'b1;
                    m_stalled++;
                end
                m_wb_valid = 1'b0;
                m_wb_rw    = 1'b0;
            end else begin
                m_wb_valid = m_slot.valid;
                m_wb_rw    = m_slot.valid && m_slot.rw;
                m_wb_reg   = m_slot.wreg;
                m_wb_data  = m_slot.m2r ? bus.dmem_rdata : m_slot.alu;
                m_slot     = ex_now();
                m_slot.valid = bus.ex_valid && !m_taken;
                m_stalled  = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic e_req;
        e_req = m_slot.valid && (m_slot.rd || m_slot.wr) && !m_err;
        check("m_dmem_req",   bus.dmem_req,      e_req);
        check("m_dmem_we",    bus.dmem_we,       m_slot.wr);
        check("m_dmem_addr",  bus.dmem_addr,     m_slot.alu & 16'hFFFE);
        check("m_dmem_wdata", bus.dmem_wdata,    m_slot.sdata);
        check("m_stall",      bus.stall,         m_err || (e_req && !bus.dmem_ack));
        check("m_pc_src",     bus.pc_src,        m_slot.valid && m_slot.br && m_slot.zero);
        check("m_br_target",  bus.branch_target, m_slot.tgt);
        check("m_err",        bus.err,           m_err);
        check("m_wb_valid",   bus.wb_valid,      m_wb_valid);
        check("m_wb_rw",      bus.wb_reg_write,  m_wb_rw);
        check("m_wb_reg",     bus.wb_write_reg,  m_wb_reg);
        check("m_wb_data",    bus.wb_data,       m_wb_data);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] tgt,
                          input logic z, input logic [DW-1:0] sd, input logic [AW-1:0] wr_reg,
                          input logic rd, input logic wr, input logic br, input logic rw,
                          input logic m2r);
        bus.ex_valid = v;          bus.ex_alu_result = alu;  bus.ex_branch_target = tgt;
        bus.ex_zero = z;           bus.ex_store_data = sd;   bus.ex_write_reg = wr_reg;
        bus.ex_mem_read = rd;      bus.ex_mem_write = wr;    bus.ex_branch = br;
        bus.ex_reg_write = rw;     bus.ex_mem_to_reg = m2r;
    endtask

    task automatic idle();
        set_ex(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int n_stall;

    initial begin
        idle();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_stall",    bus.stall,    0);
        check("rst_req",      bus.dmem_req, 0);
        check("rst_err",      bus.err,      0);
        rst_n = 1'b1;
        tick();

        // R-type
        set_ex(1, 16'h1234, 0, 0, 0, 3'd5, 0, 0, 0, 1, 0);
        tick(); idle(); #1;
        check("rt_req", bus.dmem_req, 0);
        tick();
        check("rt_wb_data",  bus.wb_data,      16'h1234);
        check("rt_wb_reg",   bus.wb_write_reg, 5);
        check("rt_wb_rw",    bus.wb_reg_write, 1);
        check("rt_wb_valid", bus.wb_valid,     1);

        // Load, ack after 3 stall cycles
        set_ex(1, 16'h0041, 0, 0, 0, 3'd2, 1, 0, 0, 1, 1);
        tick(); idle(); bus.dmem_rdata = 16'hBEEF; #1;
        check("ld_addr", bus.dmem_addr, 16'h0040);
        check("ld_we",   bus.dmem_we,   0);
        n_stall = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.stall) n_stall++;
            check("ld_wb_bubble", bus.wb_valid, 0);
            tick();
        end
        bus.dmem_ack = 1'b1; #1;
        check("ld_stall_cnt",    n_stall,   3);
        check("ld_stall_on_ack", bus.stall, 0);
        tick(); bus.dmem_ack = 1'b0;
        check("ld_wb_data",  bus.wb_data,      16'hBEEF);
        check("ld_wb_valid", bus.wb_valid,     1);
        check("ld_wb_reg",   bus.wb_write_reg, 2);

        // Store with same-cycle ack
        set_ex(1, 16'h0100, 0, 0, 16'h00A5, 3'd1, 0, 1, 0, 0, 0);
        bus.dmem_ack = 1'b1;
        tick(); idle(); #1;
        check("st_we",    bus.dmem_we,    1);
        check("st_wdata", bus.dmem_wdata, 16'h00A5);
        check("st_stall", bus.stall,      0);
        tick(); bus.dmem_ack = 1'b0;
        check("st_wb_valid", bus.wb_valid,     1);
        check("st_wb_rw",    bus.wb_reg_write, 0);

        // Taken branch squashes the following instruction
        set_ex(1, 16'h0000, 16'h0010, 1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        set_ex(1, 16'h7777, 0, 0, 0, 3'd3, 0, 0, 0, 1, 0); #1;
        check("br_pc_src", bus.pc_src,        1);
        check("br_target", bus.branch_target, 16'h0010);
        tick(); idle(); #1;
        check("br_pc_src_once", bus.pc_src, 0);
        tick();
        check("br_squash_valid", bus.wb_valid,     0);
        check("br_squash_rw",    bus.wb_reg_write, 0);

        // Not-taken branch
        set_ex(1, 16'h0000, 16'h0020, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        set_ex(1, 16'h5555, 0, 0, 0, 3'd4, 0, 0, 0, 1, 0); #1;
        check("nt_pc_src", bus.pc_src, 0);
        tick(); idle(); tick();
        check("nt_wb_valid", bus.wb_valid,     1);
        check("nt_wb_data",  bus.wb_data,      16'h5555);
        check("nt_wb_reg",   bus.wb_write_reg, 4);

        // Ack on the final permitted wait cycle completes normally
        set_ex(1, 16'h0081, 0, 0, 0, 3'd6, 1, 0, 0, 1, 1);
        tick(); idle(); bus.dmem_rdata = 16'hCAFE;
        repeat (4) tick();
        bus.dmem_ack = 1'b1; #1;
        check("bd_stall", bus.stall, 0);
        tick(); bus.dmem_ack = 1'b0;
        check("bd_err",     bus.err,     0);
        check("bd_wb_data", bus.wb_data, 16'hCAFE);

        // Timeout into sticky error
        set_ex(1, 16'h0200, 0, 0, 0, 3'd7, 1, 0, 0, 1, 1);
        tick(); idle();
        repeat (4) tick();
        check("to_err_pre",   bus.err,   0);
        check("to_stall_pre", bus.stall, 1);
        tick();
        check("to_err",   bus.err,      1);
        check("to_req",   bus.dmem_req, 0);
        check("to_stall", bus.stall,    1);
        repeat (3) tick();
        check("to_err_sticky", bus.err,   1);
        check("to_stall_hold", bus.stall, 1);
        rst_n = 1'b0; #1;
        check("to_rst_err",     bus.err,          0);
        check("to_rst_stall",   bus.stall,        0);
        check("to_rst_wb_data", bus.wb_data,      0);
        check("to_rst_wb_reg",  bus.wb_write_reg, 0);
        tick(); rst_n = 1'b1;

        // Reset while waiting, then a fresh load
        set_ex(1, 16'h0300, 0, 0, 0, 3'd1, 1, 0, 0, 1, 1);
        tick(); idle(); tick(); #1;
        check("mw_req_before", bus.dmem_req, 1);
        rst_n = 1'b0; #1;
        check("mw_req_dropped", bus.dmem_req, 0);
        check("mw_stall",       bus.stall,    0);
        check("mw_wb_valid",    bus.wb_valid, 0);
        tick(); rst_n = 1'b1;
        set_ex(1, 16'h0043, 0, 0, 0, 3'd3, 1, 0, 0, 1, 1);
        tick(); idle(); bus.dmem_rdata = 16'h1357; #1;
        check("mw_new_addr",  bus.dmem_addr, 16'h0042);
        check("mw_new_stall", bus.stall,     1);
        tick(); bus.dmem_ack = 1'b1; #1;
        check("mw_new_ack_stall", bus.stall, 0);
        tick(); bus.dmem_ack = 1'b0;
        check("mw_new_wb_data",  bus.wb_data,  16'h1357);
        check("mw_new_wb_valid", bus.wb_valid, 1);
        check("mw_new_err",      bus.err,      0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage for the 16-bit RISC core: consumes the EX stage's results (ALU result, branch target, zero flag, selected destination register) through an internal EX/MEM register. It resolves branches, performs load/store through a req/ack data-memory port with pipeline stall, and presents a registered MEM/WB bundle to write-back. It sits between the execute stage and register-file write-back, and is the downstream end of the execute stage's output interface.

## Interface
Parameters:
- DATA_W, 16, datapath/address width
- REG_AW, 3, register-index width
- TIMEOUT_CYC, 255, maximum cycles in WAIT before error (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low (one clock; reset async active-low)
- ex_valid  in  1  EX output holds a real instruction
- ex_alu_result  in  DATA_W  ALU result / memory address
- ex_branch_target  in  DATA_W  computed branch target
- ex_zero  in  1  ALU zero flag
- ex_store_data  in  DATA_W  register read data 2 (store data)
- ex_write_reg  in  REG_AW  destination register (rt/rd already muxed)
- ex_mem_read, ex_mem_write, ex_branch, ex_reg_write, ex_mem_to_reg  in  1 each  control bits
- stall  out  1  freeze upstream stages; EX holds inputs stable
- pc_src  out  1  branch taken
- branch_target  out  DATA_W  target PC when pc_src=1
- dmem_req, dmem_we  out  1  memory request / write enable
- dmem_addr, dmem_wdata  out  DATA_W  word-aligned address, store data
- dmem_rdata  in  DATA_W; dmem_ack  in  1  read data, completion
- wb_valid, wb_reg_write  out  1; wb_write_reg  out  REG_AW; wb_data  out  DATA_W
- err  out  1  sticky memory-timeout flag

## Operation
- EX/MEM register (exm_*) loads all ex_* when stall=0; exm_valid <= ex_valid & ~pc_src (squash wrong-path instruction on taken branch).
- mem_op = exm_valid & (exm_mem_read | exm_mem_write).
- dmem_req = mem_op & state≠ERR; dmem_we = exm_mem_write; dmem_addr = {exm_alu_result[DATA_W-1:1],1'b0}; dmem_wdata = exm_store_data. Held stable until ack.
- stall = (dmem_req & ~dmem_ack) | (state==ERR).
- pc_src = exm_valid & exm_branch & exm_zero; branch_target = exm_branch_target (combinational from EX/MEM).
- MEM/WB register when stall=0: wb_valid <= exm_valid; wb_reg_write <= exm_valid & exm_reg_write; wb_write_reg <= exm_write_reg; wb_data <= exm_mem_to_reg ? dmem_rdata : exm_alu_result. When stall=1: wb_valid, wb_reg_write <= 0 (bubble), others hold.
- FSM RUN/WAIT/ERR:
  - RUN→WAIT: dmem_req & ~dmem_ack; counter cleared.
  - WAIT→RUN: dmem_ack.
  - WAIT→ERR: counter==TIMEOUT_CYC-1 without ack.
  - ERR is sticky until rst_n. In ERR: err=1, dmem_req=0, stall=1.
- Wait counter is $clog2(TIMEOUT_CYC+1) bits and increments each WAIT cycle. No wrap is possible (ERR is reached first).

## Timing
- Reset: all exm_* and wb_* = 0, state RUN, counter 0, err=0. All outputs therefore 0.
- Non-memory instruction: EX inputs at edge N appear on wb_* after edge N+1 (2-cycle latency).
- Zero-wait memory (ack in the first req cycle): no stall. Load data is on wb_data after the next edge.
- k-cycle wait: stall high exactly k cycles. wb_valid is 0 for those cycles.
- pc_src is high for exactly one cycle per taken branch, and never coincides with stall (branches are not memory ops).
- Simultaneous ack and timeout boundary: ack wins → RUN.
- rst_n asserted mid-WAIT: dmem_req drops immediately (asynchronous). The transaction is abandoned.

## Structure
- Shared package: state enum (RUN, WAIT, ERR), DATA_W/REG_AW constants, and an EX/MEM control bundle typedef reused by the write-back stage.
- One natural sub-module: mem_wait_timer (counter plus timeout compare). Everything else stays flat.

## Test plan
- R-type: ex_alu_result=0x1234, ex_write_reg=5, ex_reg_write=1 → two edges later wb_data=0x1234, wb_write_reg=5, wb_reg_write=1; dmem_req never 1.
- Load, ack after 3 cycles: addr 0x0041, rdata=0xBEEF → dmem_addr=0x0040, stall=1 for 3 cycles, wb_valid=0 during stall, then wb_data=0xBEEF.
- Store, same-cycle ack: store_data=0x00A5 → dmem_we=1, dmem_wdata=0x00A5, stall never 1, wb_reg_write=0.
- Branch: branch=1, zero=1, target=0x0010 → pc_src=1 for one cycle, branch_target=0x0010, next EX instruction yields wb_valid=0. Repeat with zero=0 → pc_src=0.
- Timeout with TIMEOUT_CYC=4 and no ack → err=1 after 4 WAIT cycles, dmem_req=0, stall stays 1. Pulsing rst_n clears err and all outputs.
- Reset mid-WAIT: rst_n low during outstanding load → dmem_req=0 before the next edge, wb_*=0. After release, a new load completes normally.
